// File: rtl/arith_pkg.sv
// Shared types for the multi-cycle arithmetic unit: opcodes, FSM states and the NZCV flag bundle.
package arith_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_RSB = 3'b010,
        OP_ADC = 3'b011,
        OP_SBC = 3'b100,
        OP_MUL = 3'b101
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Flags reported for reserved opcodes: zero result, everything else clear.
    localparam flags_t FLAGS_RESERVED = '{n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0};

endpackage

// File: rtl/addsub_core.sv
// Combinational adder computing a + (b ^ {N{inv}}) + cin with ARM-style carry and overflow.
module addsub_core #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         inv_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         c_out_o,
    output logic         v_o
);

    logic [N-1:0] bx;
    logic [N:0]   full;

    assign bx      = b_i ^ {N{inv_i}};
    assign full    = {1'b0, a_i} + {1'b0, bx} + {{N{1'b0}}, cin_i};
    assign sum_o   = full[N-1:0];
    assign c_out_o = full[N];
    // Overflow: both addends share a sign that the sum does not.
    assign v_o     = (a_i[N-1] == bx[N-1]) && (sum_o[N-1] != a_i[N-1]);

endmodule

// File: rtl/arith_mc_unit.sv
// Registered ALU: single-cycle add/sub family plus an N-iteration shift-add multiplier.
// Handshake: start is taken when busy=0; valid pulses one cycle when y/flags are refreshed.
module arith_mc_unit
    import arith_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         valid,
    output logic [N-1:0] y,
    output logic [3:0]   flags
);

    localparam int CW = $clog2(N) + 1;

    state_t        state_q, state_d;
    logic [N-1:0]  y_q, y_d;
    flags_t        flags_q, flags_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;

    op_t           op_s;
    logic [N-1:0]  as_x, as_y, as_sum;
    logic          as_inv, as_cin, as_cout, as_v;
    logic [N-1:0]  acc_sum;

    assign op_s = op_t'(op);

    // Operand steering: RSB swaps the operands, subtracts invert the second one.
    always_comb begin
        as_x   = a;
        as_y   = b;
        as_inv = 1'b0;
        as_cin = 1'b0;
        case (op_s)
            OP_SUB: begin
                as_inv = 1'b1;
                as_cin = 1'b1;
            end
            OP_RSB: begin
                as_x   = b;
                as_y   = a;
                as_inv = 1'b1;
                as_cin = 1'b1;
            end
            OP_ADC: as_cin = c_in;
            OP_SBC: begin
                as_inv = 1'b1;
                as_cin = c_in;
            end
            default: ;
        endcase
    end

    addsub_core #(.N(N)) u_addsub (
        .a_i     (as_x),
        .b_i     (as_y),
        .inv_i   (as_inv),
        .cin_i   (as_cin),
        .sum_o   (as_sum),
        .c_out_o (as_cout),
        .v_o     (as_v)
    );

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : {N{1'b0}});

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        flags_d  = flags_q;
        valid_d  = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op_s)
                        OP_ADD, OP_SUB, OP_RSB, OP_ADC, OP_SBC: begin
                            y_d       = as_sum;
                            flags_d.n = as_sum[N-1];
                            flags_d.z = (as_sum == {N{1'b0}});
                            flags_d.c = as_cout;
                            flags_d.v = as_v;
                            valid_d   = 1'b1;
                        end
                        OP_MUL: begin
                            mcand_d  = a;
                            mplier_d = b;
                            acc_d    = {N{1'b0}};
                            count_d  = {CW{1'b0}};
                            state_d  = ST_MUL;
                        end
                        default: begin
                            y_d     = {N{1'b0}};
                            flags_d = FLAGS_RESERVED;
                            valid_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                // Last iteration publishes the freshly accumulated product.
                if (count_q == CW'(N - 1)) begin
                    y_d       = acc_sum;
                    flags_d.n = acc_sum[N-1];
                    flags_d.z = (acc_sum == {N{1'b0}});
                    flags_d.c = 1'b0;
                    flags_d.v = 1'b0;
                    valid_d   = 1'b1;
                    count_d   = {CW{1'b0}};
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            y_q      <= {N{1'b0}};
            flags_q  <= '0;
            valid_q  <= 1'b0;
            mcand_q  <= {N{1'b0}};
            mplier_q <= {N{1'b0}};
            acc_q    <= {N{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign busy  = (state_q == ST_MUL);
    assign valid = valid_q;
    assign y     = y_q;
    assign flags = flags_q;

endmodule

// File: doc/arith_mc_unit.md
# arith_mc_unit

Parametrised multi-cycle arithmetic unit for the ARMv4 datapath. It replaces the single-cycle add/subtract block with a registered unit that supports carry-in operations, reverse subtract and an iterative shift-add multiplier. All four ARM condition flags (NZCV) are produced. Operations are issued with a start/valid handshake from the execute-stage controller, and results are held until the next completion.

## Interface
Parameters:
- `N`, default 32: operand and result width, must be ≥ 4.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high; clears all state.
- `start`, in, 1: issue request; accepted only when `busy`=0.
- `op`, in, 3: operation code, sampled on accept.
- `a`, in, N: operand A, sampled on accept.
- `b`, in, N: operand B, sampled on accept.
- `c_in`, in, 1: carry flag for ADC/SBC, sampled on accept.
- `busy`, out, 1: multiply in progress; `start` is ignored while high.
- `valid`, out, 1: one-cycle pulse; `y`/`flags` updated this cycle.
- `y`, out, N: result, held until the next `valid`.
- `flags`, out, 4: {N,Z,C,V}, held until the next `valid`.

## Operation
- op codes:
  - 000 ADD: a+b
  - 001 SUB: a−b
  - 010 RSB: b−a
  - 011 ADC: a+b+c_in
  - 100 SBC: a−b−!c_in
  - 101 MUL: low N bits of a·b
  - 110/111 reserved
- Subtraction is computed as x + ~y + 1, or + c_in for SBC.
- C follows the ARM convention: C=1 means no borrow. This differs from the old borrow-out output and is intentional.
- V for add/sub: set when operands of the effective addition have equal sign and the result sign differs.
- N = y[N-1]. Z = (y==0).
- MUL: C=0 and V=0.
- Reserved ops complete in one cycle with y=0 and flags=0100.
- FSM states:
  - IDLE: accepts `start`.
    - Single-cycle op: registers result and flags, pulses `valid`, stays in IDLE.
    - MUL: loads multiplicand=a, multiplier=b, acc=0, count=0, then goes to MUL.
  - MUL: each cycle, if multiplier[0] then acc += multiplicand (mod 2^N); multiplicand <<= 1; multiplier >>= 1; count++.
    - On the iteration where count==N−1: write y=acc result, set flags, pulse `valid`, return to IDLE.
- Overflow of the product beyond N bits is discarded silently.

## Timing
- Reset values: `busy`=0, `valid`=0, `y`=0, `flags`=0000, state=IDLE, count=0.
- Accept at edge t. Define "accept cycle" as the cycle in which `start`=1 and `busy`=0.
- Single-cycle ops: `valid`=1 in cycle t+1. Throughput is one op per cycle; back-to-back starts give consecutive `valid` pulses.
- MUL:
  - `busy`=1 in cycles t+1 … t+N.
  - `valid`=1 in cycle t+N+1, with `busy`=0 in that same cycle.
- `start` in the `valid` cycle of a MUL is accepted (no bubble).
- `start` while `busy`=1 is dropped; it is not queued.
- Operand, op or `c_in` changes after accept have no effect.
- `reset` asserted mid-MUL aborts the operation:
  - Next cycle all outputs hold reset values and no `valid` pulse is produced.
  - A `start` in the cycle after reset deassertion is accepted normally.
- `reset` and `start` in the same cycle: reset wins and the request is lost.

## Structure
- Package `arith_pkg`: `op_t` enum (ADD, SUB, RSB, ADC, SBC, MUL), `state_t` enum (IDLE, MUL), `flags_t` packed struct {n,z,c,v}.
- Sub-module `addsub_core #(N)`: combinational a + (b xor {N{inv}}) + cin → sum, c_out, v.
  - Instantiated once for the add/sub/RSB/ADC/SBC path.
  - The MUL accumulator uses its own adder.
- Count register width is $clog2(N)+1.

## Test plan
- ADD a=0xFFFFFFFF, b=1 → cycle t+1: y=0, flags=0110, one `valid` pulse.
- ADD a=0x7FFFFFFF, b=1 → y=0x80000000, flags=1001. SUB 5−7 → y=0xFFFFFFFE, flags=1000. SUB 7−5 → y=2, flags=0010.
- ADC 1+1 with c_in=1 → y=3, C=0. SBC 5−3 with c_in=0 → y=1, flags=0010. RSB a=2, b=9 → y=7.
- MUL a=0x00010001, b=0x00010001 → `busy` high for 32 cycles; `valid` exactly 33 cycles after accept; y=0x00020001, flags=0000. A `start` issued mid-busy produces no extra `valid`.
- MUL a=0x80000000, b=2 → y=0, flags=0100. Then ADD 3+4 started in the MUL `valid` cycle → y=7 on the next cycle.
- Reset asserted 10 cycles into a MUL → next cycle `busy`=0, `y`=0, `flags`=0, and no `valid` for 40 cycles. A subsequent ADD 1+2 → y=3.
